// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, ALU and response channels of alu_arbiter
// slave  : arbiter side (accepts requests, drives the ALU inputs and the response)
// master : environment side (requesters, ALU, response consumer)
interface alu_arbiter_if #(parameter int DATA_W = 16, parameter int SEL_W = 4);
  logic              req0_valid, req0_ready;
  logic [DATA_W-1:0] req0_a, req0_b;
  logic [SEL_W-1:0]  req0_op;
  logic              req1_valid, req1_ready;
  logic [DATA_W-1:0] req1_a, req1_b;
  logic [SEL_W-1:0]  req1_op;
  logic [DATA_W-1:0] alu_in1, alu_in2, alu_out1, alu_out2;
  logic [SEL_W-1:0]  alu_select;
  logic              alu_overflow;
  logic              rsp_valid, rsp_ready, rsp_id, rsp_overflow;
  logic [DATA_W-1:0] rsp_out1, rsp_out2;
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output alu_in1, alu_in2, alu_select,
    input  alu_out1, alu_out2, alu_overflow,
    output rsp_valid, rsp_id, rsp_out1, rsp_out2, rsp_overflow,
    input  rsp_ready
  );
  modport master (
    output req0_valid, req0_a, req0_b, req0_op, req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  alu_in1, alu_in2, alu_select,
    output alu_out1, alu_out2, alu_overflow,
    input  rsp_valid, rsp_id, rsp_out1, rsp_out2, rsp_overflow,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one multi-cycle ALU between two requesters
// clk        : system clock, rising edge
// rst_n      : asynchronous active-low reset
// bus        : alu_arbiter_if.slave (req0/req1 valid/ready, ALU drive/sample, response valid/ready)
// ovf_clr    : clears ovf_sticky (only with ALU_ARB_OVF_STICKY_EN)
// ovf_sticky : set by any captured overflow (only with ALU_ARB_OVF_STICKY_EN)
module alu_arbiter #(
  parameter int DATA_W      = 16,
  parameter int SEL_W       = 4,
  parameter int ALU_LATENCY = 1
) (
  input logic clk,
  input logic rst_n,
  alu_arbiter_if.slave bus
`ifdef ALU_ARB_OVF_STICKY_EN
  ,
  input  logic ovf_clr,
  output logic ovf_sticky
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t            r_state, w_next;
  logic              r_ptr, r_id, r_rsp_valid, r_ovf;
  logic [3:0]        r_cnt;
  logic [DATA_W-1:0] r_in1, r_in2, r_out1, r_out2;
  logic [SEL_W-1:0]  r_sel;
  logic              w_g0, w_g1, w_acc, w_cap, w_rel;
  always_comb begin
    w_g0   = bus.req0_valid & (~bus.req1_valid | ~r_ptr);
    w_g1   = bus.req1_valid & (~bus.req0_valid | r_ptr);
    w_acc  = r_state == IDLE & (w_g0 | w_g1);
    w_cap  = r_state == EXEC & r_cnt == 4'(ALU_LATENCY - 1);
    w_rel  = r_state == RESP & bus.rsp_ready;
    w_next = w_acc ? EXEC : w_cap ? RESP : w_rel ? IDLE : r_state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ptr       <= 1'b0;
      r_id        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_in1       <= '0;
      r_in2       <= '0;
      r_sel       <= '0;
      r_out1      <= '0;
      r_out2      <= '0;
    end else begin
      if (w_acc) begin
        r_in1 <= w_g1 ? bus.req1_a : bus.req0_a;
        r_in2 <= w_g1 ? bus.req1_b : bus.req0_b;
        r_sel <= w_g1 ? bus.req1_op : bus.req0_op;
        r_id  <= w_g1;
        r_cnt <= '0;
      end
      if (r_state == EXEC) r_cnt <= r_cnt + 4'd1;
      if (w_cap) begin
        r_out1      <= bus.alu_out1;
        r_out2      <= bus.alu_out2;
        r_ovf       <= bus.alu_overflow;
        r_rsp_valid <= 1'b1;
      end
      if (w_rel) begin
        r_rsp_valid <= 1'b0;
        r_ptr       <= ~r_id;
      end
    end
  // ready is gated by rst_n so it reads 0 while reset is held, even with valid high
  assign bus.req0_ready   = rst_n & r_state == IDLE & w_g0;
  assign bus.req1_ready   = rst_n & r_state == IDLE & w_g1;
  assign bus.alu_in1      = r_in1;
  assign bus.alu_in2      = r_in2;
  assign bus.alu_select   = r_sel;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_id       = r_id;
  assign bus.rsp_out1     = r_out1;
  assign bus.rsp_out2     = r_out2;
  assign bus.rsp_overflow = r_ovf;
`ifdef ALU_ARB_OVF_STICKY_EN
  logic r_sticky;
  // a capture with overflow beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sticky <= 1'b0;
    else r_sticky <= (w_cap & bus.alu_overflow) | (r_sticky & ~ovf_clr);
  assign ovf_sticky = r_sticky;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter at ALU_LATENCY 1 and 3
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errs = 0;
  int checks = 0;
  logic [33:0] q[$];
  logic [33:0] e;
  always #5 clk = ~clk;
  alu_arbiter_if b1();
  alu_arbiter_if b3();
`ifdef ALU_ARB_OVF_STICKY_EN
  logic ovf_clr1 = 1'b0, ovf_clr3 = 1'b0, sticky1, sticky3;
`endif
  alu_arbiter #(.ALU_LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
`ifdef ALU_ARB_OVF_STICKY_EN
    , .ovf_clr(ovf_clr1), .ovf_sticky(sticky1)
`endif
  );
  alu_arbiter #(.ALU_LATENCY(3)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(b3)
`ifdef ALU_ARB_OVF_STICKY_EN
    , .ovf_clr(ovf_clr3), .ovf_sticky(sticky3)
`endif
  );
  function automatic logic [32:0] alu_f(logic [15:0] x, logic [15:0] y, logic [3:0] s);
    logic [15:0] o;
    o = s == 4'd1 ? x + y : s == 4'd2 ? x - y : s == 4'd3 ? x & y : 16'h0;
    return {s == 4'd1 && x[15] == y[15] && o[15] != x[15], x ^ y, o};
  endfunction
  assign {b1.alu_overflow, b1.alu_out2, b1.alu_out1} = alu_f(b1.alu_in1, b1.alu_in2, b1.alu_select);
  assign {b3.alu_overflow, b3.alu_out2, b3.alu_out1} = alu_f(b3.alu_in1, b3.alu_in2, b3.alu_select);
  logic [72:0] outs1, outs3;
  logic [33:0] rsp1, rsp3;
  assign outs1 = {b1.alu_in1, b1.alu_in2, b1.alu_select, b1.rsp_out1, b1.rsp_out2,
                  b1.rsp_valid, b1.rsp_id, b1.rsp_overflow, b1.req0_ready, b1.req1_ready};
  assign outs3 = {b3.alu_in1, b3.alu_in2, b3.alu_select, b3.rsp_out1, b3.rsp_out2,
                  b3.rsp_valid, b3.rsp_id, b3.rsp_overflow, b3.req0_ready, b3.req1_ready};
  assign rsp1 = {b1.rsp_id, b1.rsp_overflow, b1.rsp_out2, b1.rsp_out1};
  assign rsp3 = {b3.rsp_id, b3.rsp_overflow, b3.rsp_out2, b3.rsp_out1};
  task automatic test_reset;
    b1.req0_valid = 1'b1; b1.req0_a = 16'h1; b1.req0_b = 16'h1; b1.req0_op = 4'd1;
    b1.req1_valid = 1'b0; b1.req1_a = '0; b1.req1_b = '0; b1.req1_op = '0;
    b3.req0_valid = 1'b0; b3.req0_a = '0; b3.req0_b = '0; b3.req0_op = '0;
    b3.req1_valid = 1'b0; b3.req1_a = '0; b3.req1_b = '0; b3.req1_op = '0;
    b1.rsp_ready = 1'b1; b3.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (outs1 !== '0) begin errs++; $display("FAIL reset_outs1: got %h want 0", outs1); end
    checks++; if (outs3 !== '0) begin errs++; $display("FAIL reset_outs3: got %h want 0", outs3); end
`ifdef ALU_ARB_OVF_STICKY_EN
    checks++; if (sticky1 !== 1'b0) begin errs++; $display("FAIL reset_sticky: got %b want 0", sticky1); end
`endif
    b1.req0_valid = 1'b0;
    rst_n = 1'b1;
  endtask
  task automatic test_single;
    @(posedge clk); #1;
    b1.req0_valid = 1'b1; b1.req0_a = 16'h0004; b1.req0_b = 16'h0004; b1.req0_op = 4'd1;
    @(negedge clk);
    checks++; if ({b1.req0_ready, b1.req1_ready} !== 2'b10) begin errs++; $display("FAIL single_ready: got %b want 10", {b1.req0_ready, b1.req1_ready}); end
    q.push_back({1'b0, alu_f(16'h4, 16'h4, 4'd1)});
    @(posedge clk); #1 b1.req0_valid = 1'b0;
    @(negedge clk);
    checks++; if (b1.rsp_valid !== 1'b0) begin errs++; $display("FAIL single_early: rsp_valid got %b want 0", b1.rsp_valid); end
    @(negedge clk);
    checks++; if (b1.rsp_valid !== 1'b1) begin errs++; $display("FAIL single_valid: got %b want 1", b1.rsp_valid); end
    e = q.pop_front();
    checks++; if (rsp1 !== e) begin errs++; $display("FAIL single_rsp: got %h want %h", rsp1, e); end
    checks++; if ({b1.rsp_id, b1.rsp_overflow, b1.rsp_out1} !== {2'b00, 16'h0008}) begin errs++; $display("FAIL single_out1: got %h want 0008", b1.rsp_out1); end
    @(negedge clk);
    checks++; if (b1.rsp_valid !== 1'b0) begin errs++; $display("FAIL single_drop: rsp_valid got %b want 0", b1.rsp_valid); end
  endtask
  task automatic test_fair;
    int nacc = 0;
    int nrsp = 0;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    b1.req0_valid = 1'b1; b1.req0_a = 16'h0010; b1.req0_b = 16'h0001; b1.req0_op = 4'd2;
    b1.req1_valid = 1'b1; b1.req1_a = 16'h0010; b1.req1_b = 16'h0001; b1.req1_op = 4'd2;
    for (int c = 0; c < 80 && nrsp < 4; c++) begin
      @(negedge clk);
      if (b1.rsp_valid) begin
        e = q.size() > 0 ? q.pop_front() : '1;
        checks++; if (rsp1 !== e) begin errs++; $display("FAIL fair_rsp%0d: got %h want %h", nrsp, rsp1, e); end
        checks++; if (b1.rsp_out1 !== 16'h000F) begin errs++; $display("FAIL fair_out1_%0d: got %h want 000f", nrsp, b1.rsp_out1); end
        nrsp++;
      end
      if (b1.req0_ready | b1.req1_ready) begin
        checks++; if ({b1.req1_ready, b1.req0_ready} !== (nacc[0] ? 2'b10 : 2'b01)) begin errs++; $display("FAIL fair_grant%0d: got %b want id %0d", nacc, {b1.req1_ready, b1.req0_ready}, nacc[0]); end
        q.push_back({nacc[0], alu_f(16'h10, 16'h1, 4'd2)});
        nacc++;
        if (nacc == 4) begin
          @(posedge clk); #1;
          b1.req0_valid = 1'b0; b1.req1_valid = 1'b0;
        end
      end
    end
    checks++; if (nrsp != 4) begin errs++; $display("FAIL fair_timeout: got %0d responses want 4", nrsp); end
  endtask
  task automatic test_overflow;
    @(posedge clk); #1;
    b1.req1_valid = 1'b1; b1.req1_a = 16'h7FFF; b1.req1_b = 16'h0001; b1.req1_op = 4'd1;
    for (int c = 0; c < 10 && b1.req1_ready !== 1'b1; c++) @(negedge clk);
    checks++; if (b1.req1_ready !== 1'b1) begin errs++; $display("FAIL ovf_ready: got %b want 1", b1.req1_ready); end
    q.push_back({1'b1, alu_f(16'h7FFF, 16'h0001, 4'd1)});
    @(posedge clk); #1 b1.req1_valid = 1'b0;
    for (int c = 0; c < 10 && b1.rsp_valid !== 1'b1; c++) @(negedge clk);
    e = q.pop_front();
    checks++; if (rsp1 !== e) begin errs++; $display("FAIL ovf_rsp: got %h want %h", rsp1, e); end
    checks++; if ({b1.rsp_overflow, b1.rsp_out1} !== {1'b1, 16'h8000}) begin errs++; $display("FAIL ovf_out: got %b/%h want 1/8000", b1.rsp_overflow, b1.rsp_out1); end
`ifdef ALU_ARB_OVF_STICKY_EN
    repeat (3) @(negedge clk);
    checks++; if (sticky1 !== 1'b1) begin errs++; $display("FAIL ovf_sticky_hold: got %b want 1", sticky1); end
    @(posedge clk); #1 ovf_clr1 = 1'b1;
    @(posedge clk); #1 ovf_clr1 = 1'b0;
    @(negedge clk);
    checks++; if (sticky1 !== 1'b0) begin errs++; $display("FAIL ovf_sticky_clr: got %b want 0", sticky1); end
`endif
  endtask
  task automatic test_backpressure;
    @(posedge clk); #1;
    b1.rsp_ready = 1'b0;
    b1.req0_valid = 1'b1; b1.req0_a = 16'h0010; b1.req0_b = 16'h0003; b1.req0_op = 4'd2;
    @(negedge clk);
    checks++; if (b1.req0_ready !== 1'b1) begin errs++; $display("FAIL bp_ready: got %b want 1", b1.req0_ready); end
    q.push_back({1'b0, alu_f(16'h10, 16'h3, 4'd2)});
    @(posedge clk); #1;
    b1.req0_a = 16'h0005; b1.req0_b = 16'h0006; b1.req0_op = 4'd1;
    for (int c = 0; c < 10 && b1.rsp_valid !== 1'b1; c++) @(negedge clk);
    e = q.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++; if ({b1.rsp_valid, rsp1} !== {1'b1, e}) begin errs++; $display("FAIL bp_hold%0d: got %b/%h want 1/%h", i, b1.rsp_valid, rsp1, e); end
      checks++; if ({b1.req0_ready, b1.alu_in1, b1.alu_in2, b1.alu_select} !== {1'b0, 16'h0010, 16'h0003, 4'd2}) begin errs++; $display("FAIL bp_frozen%0d: got %b/%h/%h/%h", i, b1.req0_ready, b1.alu_in1, b1.alu_in2, b1.alu_select); end
      @(negedge clk);
    end
    @(posedge clk); #1 b1.rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (b1.req0_ready !== 1'b0) begin errs++; $display("FAIL bp_early_ready: got %b want 0", b1.req0_ready); end
    @(negedge clk);
    checks++; if (b1.req0_ready !== 1'b1) begin errs++; $display("FAIL bp_next_ready: got %b want 1", b1.req0_ready); end
    q.push_back({1'b0, alu_f(16'h5, 16'h6, 4'd1)});
    @(posedge clk); #1 b1.req0_valid = 1'b0;
    for (int c = 0; c < 10 && b1.rsp_valid !== 1'b1; c++) @(negedge clk);
    e = q.pop_front();
    checks++; if ({b1.rsp_valid, rsp1} !== {1'b1, e}) begin errs++; $display("FAIL bp_second: got %b/%h want 1/%h", b1.rsp_valid, rsp1, e); end
  endtask
  task automatic test_latency;
    @(posedge clk); #1;
    b3.req0_valid = 1'b1; b3.req0_a = 16'h00F0; b3.req0_b = 16'h0FF0; b3.req0_op = 4'd3;
    @(negedge clk);
    checks++; if (b3.req0_ready !== 1'b1) begin errs++; $display("FAIL lat_ready: got %b want 1", b3.req0_ready); end
    q.push_back({1'b0, alu_f(16'h00F0, 16'h0FF0, 4'd3)});
    @(posedge clk); #1 b3.req0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({b3.rsp_valid, b3.alu_in1, b3.alu_in2, b3.alu_select} !== {1'b0, 16'h00F0, 16'h0FF0, 4'd3}) begin errs++; $display("FAIL lat_exec%0d: got %b/%h/%h/%h", i, b3.rsp_valid, b3.alu_in1, b3.alu_in2, b3.alu_select); end
      @(posedge clk);
    end
    @(negedge clk);
    e = q.pop_front();
    checks++; if ({b3.rsp_valid, rsp3} !== {1'b1, e}) begin errs++; $display("FAIL lat_rsp: got %b/%h want 1/%h", b3.rsp_valid, rsp3, e); end
    checks++; if (b3.rsp_out1 !== 16'h00F0) begin errs++; $display("FAIL lat_out1: got %h want 00f0", b3.rsp_out1); end
  endtask
  task automatic test_reset_mid;
    @(posedge clk); #1;
    b1.req0_valid = 1'b1; b1.req0_a = 16'h0001; b1.req0_b = 16'h0002; b1.req0_op = 4'd1;
    @(posedge clk); #1 b1.req0_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (outs1 !== '0) begin errs++; $display("FAIL rstmid_outs: got %h want 0", outs1); end
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    b1.req0_valid = 1'b1; b1.req0_a = 16'h0003; b1.req0_b = 16'h0005; b1.req0_op = 4'd1;
    @(negedge clk);
    checks++; if (b1.req0_ready !== 1'b1) begin errs++; $display("FAIL rstmid_ready: got %b want 1", b1.req0_ready); end
    q.push_back({1'b0, alu_f(16'h3, 16'h5, 4'd1)});
    @(posedge clk); #1 b1.req0_valid = 1'b0;
    @(negedge clk);
    checks++; if (b1.rsp_valid !== 1'b0) begin errs++; $display("FAIL rstmid_early: got %b want 0", b1.rsp_valid); end
    @(negedge clk);
    e = q.pop_front();
    checks++; if ({b1.rsp_valid, rsp1} !== {1'b1, e}) begin errs++; $display("FAIL rstmid_rsp: got %b/%h want 1/%h", b1.rsp_valid, rsp1, e); end
    checks++; if (b1.rsp_out1 !== 16'h0008) begin errs++; $display("FAIL rstmid_out1: got %h want 0008", b1.rsp_out1); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_single;
    test_fair;
    test_overflow;
    test_backpressure;
    test_latency;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one 16-bit ALU instance between two requesters (e.g. the execute stage and the address/branch unit). Runs round-robin arbitration with valid/ready handshakes. Registers operands and select onto the ALU inputs and waits a programmable number of cycles for the ALU to settle. Captures out1/out2/overflow and returns them with the requester ID over a valid/ready response channel.

Parameters:
DATA_W, 16, operand/result width (ALU in1/in2/out1/out2)
SEL_W, 4, ALU select width
ALU_LATENCY, 1, cycles between driving ALU inputs and sampling ALU outputs; legal 1..15

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  DATA_W  requester 0 operand 1
req0_b  input  DATA_W  requester 0 operand 2
req0_op  input  SEL_W  requester 0 ALU select
req1_valid, req1_ready, req1_a, req1_b, req1_op  as above for requester 1
alu_in1  output  DATA_W  to ALU in1 (registered)
alu_in2  output  DATA_W  to ALU in2 (registered)
alu_select  output  SEL_W  to ALU select (registered)
alu_out1  input  DATA_W  from ALU out1
alu_out2  input  DATA_W  from ALU out2
alu_overflow  input  1  from ALU overflow
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_id  output  1  requester that issued the result
rsp_out1  output  DATA_W  captured out1
rsp_out2  output  DATA_W  captured out2
rsp_overflow  output  1  captured overflow

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values:
  - state=IDLE, priority pointer=0 (req0 favoured), latency counter=0.
  - alu_in1/alu_in2/alu_select/rsp_out1/rsp_out2 = 0.
  - rsp_valid/rsp_overflow/rsp_id/req0_ready/req1_ready = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational from the valid inputs and the pointer.
  - Exactly one reqN_ready is asserted in the same cycle as the grant. reqN_ready=0 in every other state.
  - Only one valid: that requester wins. Both valid: requester == pointer wins.
  - On handshake (valid && ready): latch a→alu_in1, b→alu_in2, op→alu_select, N→rsp_id. Clear the counter. Go to EXEC.
  - No valid: stay in IDLE; ALU inputs hold their last issued values.
- EXEC:
  - ALU inputs stay stable. The counter increments each cycle.
  - When counter==ALU_LATENCY-1: capture alu_out1/alu_out2/alu_overflow into the rsp_* registers, set rsp_valid=1, go to RESP.
  - With ALU_LATENCY=1, outputs are sampled on the first EXEC cycle.
- RESP:
  - rsp_valid=1 and rsp_* are held stable until rsp_ready.
  - On rsp_valid && rsp_ready: rsp_valid=0, pointer = ~rsp_id (last winner becomes lowest priority), go to IDLE.
  - New requests are not accepted while in EXEC or RESP; requesters hold valid and payload until ready.
- Timing:
  - Request-accept to rsp_valid: ALU_LATENCY+1 clk edges.
  - Minimum issue interval: ALU_LATENCY+2 cycles, with rsp_ready tied high.
- Boundary rules:
  - Valid dropped before ready: no capture, no state change.
  - Back-pressure on rsp_ready: no requests accepted; ALU inputs frozen.
  - Reset mid-EXEC or mid-RESP: transaction discarded, all registers return to reset values immediately.
  - Results are passed through unmodified; no width extension or truncation.
  - select values unsupported by the ALU are forwarded unchanged.

Optional Feature:
ALU_ARB_OVF_STICKY_EN
- Defined: adds output ovf_sticky (1) and input ovf_clr (1).
  - ovf_sticky sets on any result capture with alu_overflow=1.
  - It clears on ovf_clr=1. If both happen in the same cycle, set wins.
  - Reset value 0.
- Undefined: neither port exists; no sticky logic.

Test Plan:
- Test setup: ALU model in the bench gives out1=in1+in2 for select=1, in1-in2 for select=2, in1&in2 for select=3; overflow is signed-add overflow.
- Single req0 request (a=0x0004, b=0x0004, op=1) with ALU_LATENCY=1 and rsp_ready=1:
  - req0_ready is high in cycle 0.
  - rsp_valid is high 2 edges later with rsp_out1=0x0008, rsp_id=0, rsp_overflow=0.
- req0 and req1 valid from reset, both with op=2, a=0x0010, b=0x0001:
  - Grant order is 0,1,0,1.
  - Each rsp_out1=0x000F.
  - Arbitration is fair across 4 transactions.
- req1 a=0x7FFF, b=0x0001, op=1:
  - rsp_out1=0x8000, rsp_overflow=1.
  - With ALU_ARB_OVF_STICKY_EN, ovf_sticky=1 until ovf_clr is pulsed.
- Back-pressure: rsp_ready=0 for 5 cycles after rsp_valid, with req0_valid held high:
  - rsp_* stay stable and req0_ready stays 0.
  - The request is accepted the cycle after the response handshake.
- Latency: ALU_LATENCY=3, op=3, a=0x00F0, b=0x0FF0:
  - rsp_valid arrives 4 edges after accept, with rsp_out1=0x00F0.
  - alu_in1/alu_in2/alu_select are stable throughout EXEC.
- Reset: assert rst_n=0 during EXEC:
  - All outputs go to 0 asynchronously.
  - After release, a new req0 transaction completes normally.
